// File: rtl/traffic_controller_nway.sv
// N-way round-robin traffic controller with emergency pre-emption.
// Moore lamps decode from the registered phase/way; a down-counter times each phase.
module traffic_controller_nway #(
    parameter int N_WAYS     = 4,
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 2,
    parameter int CNT_W      = 8,
    parameter int WAY_W      = $clog2(N_WAYS)
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              en,
    input  logic [N_WAYS-1:0] req,
    input  logic              emg,
    input  logic [WAY_W-1:0]  emg_way,
    output logic [N_WAYS-1:0] green,
    output logic [N_WAYS-1:0] yellow,
    output logic [N_WAYS-1:0] red,
    output logic [WAY_W-1:0]  active_way,
    output logic [1:0]        phase
);

    typedef enum logic [1:0] {
        ALL_RED   = 2'd0,
        GREEN     = 2'd1,
        YELLOW    = 2'd2,
        EMG_GREEN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] L_GREEN  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(ALLRED_CYC - 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_timer, w_timer_nxt;
    logic [WAY_W-1:0]   r_way, w_way_nxt;

    logic [N_WAYS-1:0]  w_sel;
    logic               w_expire;
    logic               w_other_req;
    logic               w_found;
    logic [WAY_W-1:0]   w_winner;
    logic [WAY_W-1:0]   w_idx;

    assign w_sel       = N_WAYS'(1) << r_way;
    assign w_expire    = (r_timer == '0);
    assign w_other_req = |(req & ~w_sel);

    // Round-robin scan starts just after the last served way; that way is checked last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_way;
        w_idx    = '0;
        for (int k = 1; k <= N_WAYS; k++) begin
            w_idx = WAY_W'((int'(r_way) + k) % N_WAYS);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer - CNT_W'(1);
        w_way_nxt   = r_way;
        case (r_state)
            ALL_RED: begin
                if (w_expire) begin
                    if (emg) begin
                        w_state_nxt = EMG_GREEN;
                        w_way_nxt   = emg_way;
                        w_timer_nxt = L_GREEN;
                    end else if (w_found) begin
                        w_state_nxt = GREEN;
                        w_way_nxt   = w_winner;
                        w_timer_nxt = L_GREEN;
                    end else begin
                        w_timer_nxt = L_ALLRED;
                    end
                end
            end
            GREEN: begin
                if (emg && (emg_way != r_way)) begin
                    w_state_nxt = YELLOW;
                    w_timer_nxt = L_YELLOW;
                end else if (emg) begin
                    w_state_nxt = EMG_GREEN;
                    w_timer_nxt = L_GREEN;
                end else if (w_expire) begin
                    if (w_other_req) begin
                        w_state_nxt = YELLOW;
                        w_timer_nxt = L_YELLOW;
                    end else begin
                        w_timer_nxt = L_GREEN;
                    end
                end
            end
            YELLOW: begin
                if (w_expire) begin
                    w_state_nxt = ALL_RED;
                    w_timer_nxt = L_ALLRED;
                end
            end
            EMG_GREEN: begin
                // Timer is parked while pre-empted; emg_way changes are ignored here.
                w_timer_nxt = r_timer;
                if (!emg) begin
                    w_state_nxt = YELLOW;
                    w_timer_nxt = L_YELLOW;
                end
            end
            default: begin
                w_state_nxt = ALL_RED;
                w_timer_nxt = L_ALLRED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= ALL_RED;
            r_timer <= L_ALLRED;
            r_way   <= WAY_W'(N_WAYS - 1);
        end else if (en) begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_way   <= w_way_nxt;
        end
    end

    assign green      = ((r_state == GREEN) || (r_state == EMG_GREEN)) ? w_sel : '0;
    assign yellow     = (r_state == YELLOW) ? w_sel : '0;
    assign red        = ~(green | yellow);
    assign active_way = r_way;
    assign phase      = r_state;

endmodule

// File: tb/tb_traffic_controller_nway.sv
// Directed bench for traffic_controller_nway: 4-way default instance plus
// 2-way and 5-way single-cycle instances for the parameter sweep.
module tb_traffic_controller_nway;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res_n, en, emg;
    logic [3:0] req;
    logic [1:0] emg_way;
    logic [3:0] g, y, r;
    logic [1:0] aw, ph;

    logic [1:0] req2, g2, y2, r2, ph2;
    logic [0:0] emg_way2, aw2;
    logic [4:0] req5, g5, y5, r5;
    logic [2:0] emg_way5, aw5;
    logic [1:0] ph5;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_controller_nway dut (
        .clk(clk), .res_n(res_n), .en(en), .req(req), .emg(emg), .emg_way(emg_way),
        .green(g), .yellow(y), .red(r), .active_way(aw), .phase(ph)
    );

    traffic_controller_nway #(.N_WAYS(2), .GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1)) dut2 (
        .clk(clk), .res_n(res_n), .en(en), .req(req2), .emg(1'b0), .emg_way(emg_way2),
        .green(g2), .yellow(y2), .red(r2), .active_way(aw2), .phase(ph2)
    );

    traffic_controller_nway #(.N_WAYS(5), .GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1)) dut5 (
        .clk(clk), .res_n(res_n), .en(en), .req(req5), .emg(1'b0), .emg_way(emg_way5),
        .green(g5), .yellow(y5), .red(r5), .active_way(aw5), .phase(ph5)
    );

    // Lamp invariants on every instance, plus green-to-red skip detection.
    logic [3:0] prev_g;
    logic [4:0] prev_g5;
    always @(negedge clk) begin
        if (res_n !== 1'b1) begin
            prev_g  = '0;
            prev_g5 = '0;
        end else begin
            n_checks++;
            if (!$onehot0(g | y) || r !== ~(g | y) || (prev_g & r) != 0) begin
                n_fail++;
                $display("FAIL inv4: g=%b y=%b r=%b prev_g=%b", g, y, r, prev_g);
            end
            n_checks++;
            if (!$onehot0(g2 | y2) || r2 !== ~(g2 | y2)) begin
                n_fail++;
                $display("FAIL inv2: g=%b y=%b r=%b", g2, y2, r2);
            end
            n_checks++;
            if (!$onehot0(g5 | y5) || r5 !== ~(g5 | y5) || (prev_g5 & r5) != 0) begin
                n_fail++;
                $display("FAIL inv5: g=%b y=%b r=%b prev_g=%b", g5, y5, r5, prev_g5);
            end
            prev_g  = g;
            prev_g5 = g5;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] rq);
        res_n   = 1'b0;
        en      = 1'b1;
        emg     = 1'b0;
        emg_way = 2'd0;
        req     = rq;
        repeat (3) tick();
        res_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset(4'b0100);
        n_checks++;
        if (aw !== 2'd3 || g !== 4'b0000 || y !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: aw=%0d g=%b y=%b, want aw=3 g=0000 y=0000", aw, g, y);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (r !== 4'b1111 || ph !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_allred[%0d]: r=%b ph=%0d, want r=1111 ph=0", i, r, ph);
            end
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (g !== 4'b0100 || aw !== 2'd2 || ph !== 2'd1) begin
                n_fail++;
                $display("FAIL single_green[%0d]: g=%b aw=%0d ph=%0d, want g=0100 aw=2 ph=1", i, g, aw, ph);
            end
            tick();
        end
    endtask

    task automatic test_round_robin;
        int seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp;
        do_reset(4'b1111);
        tick();
        tick();
        for (int s = 0; s < 5; s++) begin
            exp = 4'b0001 << seq[s];
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (g !== exp || ph !== 2'd1) begin
                    n_fail++;
                    $display("FAIL rr_green[%0d.%0d]: g=%b ph=%0d, want g=%b ph=1", s, i, g, ph, exp);
                end
                tick();
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (y !== exp || g !== 4'b0000 || ph !== 2'd2) begin
                    n_fail++;
                    $display("FAIL rr_yellow[%0d.%0d]: y=%b g=%b ph=%0d, want y=%b", s, i, y, g, ph, exp);
                end
                tick();
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (r !== 4'b1111 || ph !== 2'd0) begin
                    n_fail++;
                    $display("FAIL rr_allred[%0d.%0d]: r=%b ph=%0d, want r=1111 ph=0", s, i, r, ph);
                end
                tick();
            end
        end
    endtask

    task automatic test_emergency;
        do_reset(4'b1111);
        repeat (5) tick();
        emg     = 1'b1;
        emg_way = 2'd2;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (y !== 4'b0001 || ph !== 2'd2) begin
                n_fail++;
                $display("FAIL emg_yellow0[%0d]: y=%b ph=%0d, want y=0001 ph=2", i, y, ph);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (r !== 4'b1111 || ph !== 2'd0) begin
                n_fail++;
                $display("FAIL emg_allred[%0d]: r=%b ph=%0d, want r=1111 ph=0", i, r, ph);
            end
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (g !== 4'b0100 || ph !== 2'd3 || aw !== 2'd2) begin
                n_fail++;
                $display("FAIL emg_hold[%0d]: g=%b ph=%0d aw=%0d, want g=0100 ph=3 aw=2", i, g, ph, aw);
            end
            if (i == 5) emg_way = 2'd1;
            tick();
        end
        emg = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (y !== 4'b0100 || ph !== 2'd2) begin
                n_fail++;
                $display("FAIL emg_yellow2[%0d]: y=%b ph=%0d, want y=0100 ph=2", i, y, ph);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (r !== 4'b1111 || ph !== 2'd0) begin
                n_fail++;
                $display("FAIL emg_allred2[%0d]: r=%b ph=%0d, want r=1111 ph=0", i, r, ph);
            end
            tick();
        end
        n_checks++;
        if (g !== 4'b1000 || aw !== 2'd3 || ph !== 2'd1) begin
            n_fail++;
            $display("FAIL emg_resume: g=%b aw=%0d ph=%0d, want g=1000 aw=3 ph=1", g, aw, ph);
        end
    endtask

    task automatic test_enable_freeze;
        do_reset(4'b1111);
        repeat (10) tick();
        n_checks++;
        if (y !== 4'b0001 || ph !== 2'd2) begin
            n_fail++;
            $display("FAIL freeze_pre: y=%b ph=%0d, want y=0001 ph=2", y, ph);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (y !== 4'b0001 || ph !== 2'd2) begin
                n_fail++;
                $display("FAIL freeze_hold[%0d]: y=%b ph=%0d, want y=0001 ph=2", i, y, ph);
            end
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (y !== 4'b0001 || ph !== 2'd2) begin
            n_fail++;
            $display("FAIL freeze_remain: y=%b ph=%0d, want y=0001 ph=2", y, ph);
        end
        tick();
        n_checks++;
        if (r !== 4'b1111 || ph !== 2'd0) begin
            n_fail++;
            $display("FAIL freeze_done: r=%b ph=%0d, want r=1111 ph=0", r, ph);
        end
    endtask

    task automatic test_idle_async_reset;
        do_reset(4'b0000);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (ph !== 2'd0 || aw !== 2'd3 || r !== 4'b1111) begin
                n_fail++;
                $display("FAIL idle[%0d]: ph=%0d aw=%0d r=%b, want ph=0 aw=3 r=1111", i, ph, aw, r);
            end
            tick();
        end
        req = 4'b0100;
        repeat (3) tick();
        n_checks++;
        if (g !== 4'b0100 || ph !== 2'd1) begin
            n_fail++;
            $display("FAIL idle_grant: g=%b ph=%0d, want g=0100 ph=1", g, ph);
        end
        #3;
        res_n = 1'b0;
        #1;
        n_checks++;
        if (r !== 4'b1111 || g !== 4'b0000 || ph !== 2'd0 || aw !== 2'd3) begin
            n_fail++;
            $display("FAIL async_reset: r=%b g=%b ph=%0d aw=%0d, want r=1111 g=0000 ph=0 aw=3", r, g, ph, aw);
        end
        #2;
        res_n = 1'b1;
        req   = 4'b0000;
    endtask

    task automatic test_param_sweep;
        logic [1:0] e2;
        logic [4:0] e5;
        req2 = 2'b11;
        req5 = 5'b11111;
        do_reset(4'b0000);
        n_checks++;
        if (r2 !== 2'b11 || r5 !== 5'b11111 || aw2 !== 1'b1 || aw5 !== 3'd4) begin
            n_fail++;
            $display("FAIL sweep_reset: r2=%b r5=%b aw2=%0d aw5=%0d", r2, r5, aw2, aw5);
        end
        tick();
        for (int s = 0; s < 6; s++) begin
            e2 = 2'b01 << (s % 2);
            e5 = 5'b00001 << (s % 5);
            n_checks++;
            if (g2 !== e2 || g5 !== e5 || ph2 !== 2'd1 || ph5 !== 2'd1) begin
                n_fail++;
                $display("FAIL sweep_green[%0d]: g2=%b g5=%b, want g2=%b g5=%b", s, g2, g5, e2, e5);
            end
            tick();
            n_checks++;
            if (y2 !== e2 || y5 !== e5 || ph2 !== 2'd2 || ph5 !== 2'd2) begin
                n_fail++;
                $display("FAIL sweep_yellow[%0d]: y2=%b y5=%b, want y2=%b y5=%b", s, y2, y5, e2, e5);
            end
            tick();
            n_checks++;
            if (r2 !== 2'b11 || r5 !== 5'b11111 || ph2 !== 2'd0 || ph5 !== 2'd0) begin
                n_fail++;
                $display("FAIL sweep_allred[%0d]: r2=%b r5=%b ph2=%0d ph5=%0d", s, r2, r5, ph2, ph5);
            end
            tick();
        end
        req2 = 2'b00;
        req5 = 5'b00000;
    endtask

    initial begin
        res_n    = 1'b0;
        en       = 1'b1;
        emg      = 1'b0;
        emg_way  = 2'd0;
        req      = 4'b0000;
        req2     = 2'b00;
        req5     = 5'b00000;
        emg_way2 = 1'b0;
        emg_way5 = 3'd0;
        test_reset();
        test_round_robin();
        test_emergency();
        test_enable_freeze();
        test_idle_async_reset();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
